// File: rtl/moving_average_pkg.sv
// moving_average_pkg: shared state type and sizing helpers
// for the multichannel boxcar prefilter.
package moving_average_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } fsm_state_t;

  function automatic int sum_width(
    input int data_width,
    input int max_window_log2
  );
    return data_width + max_window_log2;
  endfunction

  function automatic int history_depth(
    input int max_window_log2
  );
    return 1 << max_window_log2;
  endfunction

  localparam int HISTORY_DEPTH = history_depth(4);

endpackage

// File: rtl/ma_history_ram.sv
// ma_history_ram: simple dual-port sample history,
// one-cycle synchronous read, no internal bypass.
module ma_history_ram
  import moving_average_pkg::*;
#(
  parameter int DEPTH = HISTORY_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/moving_average_prefilter.sv
// moving_average_prefilter: per-channel boxcar average.
// Define MOVING_AVERAGE_ROUNDING_EN for round-half-up output.
module moving_average_prefilter
  import moving_average_pkg::*;
#(
  parameter int N_CHANNELS      = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_WINDOW_LOG2 = 4,
  parameter int DEST_WIDTH      = 4,
  localparam int KW = $clog2(MAX_WINDOW_LOG2 + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_data,
  input  logic [DEST_WIDTH-1:0] data_in_dest,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out_data,
  output logic [DEST_WIDTH-1:0] data_out_dest,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  input  logic [KW-1:0]         window_log2
);

  localparam int D  = history_depth(MAX_WINDOW_LOG2);
  localparam int PW = MAX_WINDOW_LOG2;
  localparam int CW =
    (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int AW = CW + PW;
  localparam int SW =
    sum_width(DATA_WIDTH, MAX_WINDOW_LOG2);
  localparam logic [AW-1:0] LAST =
    AW'(N_CHANNELS * D - 1);
  localparam logic [KW-1:0] KMAX =
    KW'(MAX_WINDOW_LOG2);
  localparam logic [DEST_WIDTH-1:0] NCH =
    DEST_WIDTH'(N_CHANNELS);

  fsm_state_t state, state_n;

  logic [KW-1:0] win_q, k;
  logic [AW-1:0] clr_addr;
  logic signed [SW-1:0] sum [N_CHANNELS];
  logic [PW-1:0] wptr [N_CHANNELS];

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_x;
  logic [CW-1:0]         s1_c;
  logic [PW-1:0]         s1_wp;
  logic                  byp;
  logic [DATA_WIDTH-1:0] byp_x;

  logic change, run, en, take, fire, fwd;
  logic [CW-1:0] in_c;
  logic [PW-1:0] in_wp, w_low;
  logic [AW-1:0] rd_addr, wr_addr, s2_addr;
  logic          we;
  logic [DATA_WIDTH-1:0] wd, ram_q, oldest;
  logic signed [SW-1:0] s_new;
  logic signed [SW:0]   s_ext, s_adj;
  logic [DATA_WIDTH-1:0] avg;

  assign k = (win_q > KMAX) ? KMAX : win_q;
  assign change = (win_q != window_log2);
  assign run = (state == RUN);
  assign en = !data_out_valid | data_out_ready;
  assign data_in_ready = en & run & !change;
  assign take = data_in_valid & data_in_ready
              & (data_in_dest < NCH);
  assign fire = en & s1_valid & run;

  assign in_c = data_in_dest[CW-1:0];
  // A same-channel sample still in stage 1 has not
  // bumped its pointer yet, so account for it here.
  assign fwd = s1_valid && (s1_c == in_c);
  assign in_wp = wptr[in_c] + PW'(fwd);
  assign w_low = PW'((PW + 1)'(1) << k);
  assign rd_addr = {in_c, in_wp - w_low};
  assign s2_addr = {s1_c, s1_wp};

  assign we = !run | fire;
  assign wr_addr = run ? s2_addr : clr_addr;
  assign wd = run ? s1_x : '0;

  ma_history_ram #(
    .DEPTH(N_CHANNELS * D),
    .AW   (AW),
    .DW   (DATA_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (we),
    .wa   (wr_addr),
    .wd   (wd),
    .re   (take),
    .ra   (rd_addr),
    .q    (ram_q)
  );

  assign oldest = byp ? byp_x : ram_q;
  assign s_new = sum[s1_c]
               + SW'($signed(s1_x))
               - SW'($signed(oldest));
  assign s_ext = (SW + 1)'(s_new);

`ifdef MOVING_AVERAGE_ROUNDING_EN
  logic [SW:0] half;
  assign half = (k == '0) ? '0 :
    (SW + 1)'(1) << (k - KW'(1));
  assign s_adj = s_ext + $signed(half);
`else
  assign s_adj = s_ext;
`endif

  assign avg = DATA_WIDTH'(s_adj >>> k);

  always_ff @(posedge clock) begin
    if (!reset) state <= CLEAR;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CLEAR:
        if (!change && clr_addr == LAST)
          state_n = RUN;
      RUN:
        if (change) state_n = CLEAR;
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      win_q          <= window_log2;
      clr_addr       <= '0;
      s1_valid       <= 1'b0;
      s1_x           <= '0;
      s1_c           <= '0;
      s1_wp          <= '0;
      byp            <= 1'b0;
      byp_x          <= '0;
      data_out_valid <= 1'b0;
      data_out_data  <= '0;
      data_out_dest  <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        sum[i]  <= '0;
        wptr[i] <= '0;
      end
    end else if (change) begin
      win_q          <= window_log2;
      clr_addr       <= '0;
      s1_valid       <= 1'b0;
      data_out_valid <= 1'b0;
    end else if (!run) begin
      clr_addr <= clr_addr + AW'(1);
      for (int i = 0; i < N_CHANNELS; i++) begin
        sum[i]  <= '0;
        wptr[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= take;
      if (take) begin
        s1_x  <= data_in_data;
        s1_c  <= in_c;
        s1_wp <= in_wp;
        byp   <= fire && (rd_addr == s2_addr);
        byp_x <= s1_x;
      end
      data_out_valid <= s1_valid;
      if (s1_valid) begin
        data_out_data <= avg;
        data_out_dest <= DEST_WIDTH'(s1_c);
        sum[s1_c]     <= s_new;
        wptr[s1_c]    <= s1_wp + PW'(1);
      end
    end
  end

endmodule
